// File: rtl/mest_pro_sequencer.sv
// MEST Pro instruction sequencer: fetch, operand read, ALU handshake, writeback.
// One instruction in flight; stops on HALT or at the last ROM word.
module mest_pro_sequencer #(
  parameter int OP_CODE_SIZE = 4,
  parameter int REG_ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 8 + 8 + 8,
  parameter int ROM_DEPTH = 65536,
  parameter logic [OP_CODE_SIZE-1:0] NOP_OPCODE = '0,
  parameter logic [OP_CODE_SIZE-1:0] HALT_OPCODE = '1,
  localparam int PC_W = $clog2(ROM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  output logic [PC_W-1:0]             o_rom_addr,
  output logic                        o_rom_rd,
  input  logic [INSTRUCTION_SIZE-1:0] i_rom_data,
  output logic [REG_ADDR_W-1:0]       o_rf_raddr_a,
  output logic [REG_ADDR_W-1:0]       o_rf_raddr_b,
  input  logic [DATA_W-1:0]           i_rf_rdata_a,
  input  logic [DATA_W-1:0]           i_rf_rdata_b,
  output logic                        o_rf_we,
  output logic [REG_ADDR_W-1:0]       o_rf_waddr,
  output logic [DATA_W-1:0]           o_rf_wdata,
  output logic                        o_alu_req,
  output logic [OP_CODE_SIZE-1:0]     o_alu_op,
  output logic [DATA_W-1:0]           o_alu_a,
  output logic [DATA_W-1:0]           o_alu_b,
  input  logic                        i_alu_ack,
  input  logic [DATA_W-1:0]           i_alu_result,
  input  logic                        i_alu_carry,
  input  logic                        i_alu_zero,
  output logic [DATA_W-1:0]           o_result,
  output logic                        o_valid_result,
  output logic                        o_carry,
  output logic                        o_zero_flag,
  output logic                        o_all_done
);

  localparam int SB_LSB = 0;
  localparam int SA_LSB = REG_ADDR_W;
  localparam int DST_LSB = 2 * REG_ADDR_W;
  localparam int OP_LSB = 3 * REG_ADDR_W;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(ROM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, OPERAND, EXEC, WB, DONE
  } state_t;

  state_t                  state;
  logic [PC_W-1:0]         pc;
  logic [PC_W-1:0]         pc_next;
  logic                    at_end;
  logic [OP_CODE_SIZE-1:0] ir_op;
  logic [REG_ADDR_W-1:0]   ir_dest;
  logic [OP_CODE_SIZE-1:0] dec_op;
  logic                    dec_alu;

  assign pc_next = pc + 1'b1;
  assign at_end  = (pc == PC_LAST);
  assign dec_op  = i_rom_data[OP_LSB +: OP_CODE_SIZE];
  assign dec_alu = (state == DECODE) &&
                   (dec_op != NOP_OPCODE) &&
                   (dec_op != HALT_OPCODE);

  // The RF reads synchronously, so addresses must be up during DECODE itself.
  assign o_rf_raddr_a = dec_alu ? i_rom_data[SA_LSB +: REG_ADDR_W] : '0;
  assign o_rf_raddr_b = dec_alu ? i_rom_data[SB_LSB +: REG_ADDR_W] : '0;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      pc             <= '0;
      ir_op          <= '0;
      ir_dest        <= '0;
      o_rom_addr     <= '0;
      o_rom_rd       <= 1'b0;
      o_rf_we        <= 1'b0;
      o_rf_waddr     <= '0;
      o_rf_wdata     <= '0;
      o_alu_req      <= 1'b0;
      o_alu_op       <= '0;
      o_alu_a        <= '0;
      o_alu_b        <= '0;
      o_result       <= '0;
      o_valid_result <= 1'b0;
      o_carry        <= 1'b0;
      o_zero_flag    <= 1'b0;
      o_all_done     <= 1'b0;
    end else begin
      o_rom_rd       <= 1'b0;
      o_rf_we        <= 1'b0;
      o_valid_result <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state      <= FETCH;
            o_rom_rd   <= 1'b1;
            o_rom_addr <= pc;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          ir_op   <= dec_op;
          ir_dest <= i_rom_data[DST_LSB +: REG_ADDR_W];
          if (dec_op == HALT_OPCODE) begin
            state      <= DONE;
            o_all_done <= 1'b1;
          end else if (dec_op == NOP_OPCODE) begin
            if (at_end) begin
              state      <= DONE;
              o_all_done <= 1'b1;
            end else begin
              pc         <= pc_next;
              state      <= FETCH;
              o_rom_rd   <= 1'b1;
              o_rom_addr <= pc_next;
            end
          end else begin
            state <= OPERAND;
          end
        end
        OPERAND: begin
          o_alu_a   <= i_rf_rdata_a;
          o_alu_b   <= i_rf_rdata_b;
          o_alu_op  <= ir_op;
          o_alu_req <= 1'b1;
          state     <= EXEC;
        end
        EXEC: begin
          if (i_alu_ack) begin
            o_alu_req      <= 1'b0;
            o_rf_we        <= 1'b1;
            o_rf_waddr     <= ir_dest;
            o_rf_wdata     <= i_alu_result;
            o_valid_result <= 1'b1;
            o_result       <= i_alu_result;
            o_carry        <= i_alu_carry;
            o_zero_flag    <= i_alu_zero;
            state          <= WB;
          end
        end
        WB: begin
          if (at_end) begin
            state      <= DONE;
            o_all_done <= 1'b1;
          end else begin
            pc         <= pc_next;
            state      <= FETCH;
            o_rom_rd   <= 1'b1;
            o_rom_addr <= pc_next;
          end
        end
        DONE: begin
          if (i_start) begin
            o_all_done <= 1'b0;
            pc         <= '0;
            state      <= FETCH;
            o_rom_rd   <= 1'b1;
            o_rom_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
